// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the bit-serial ALU: default operand width, opcode
// encoding and FSM state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    // FSM state encoding kept as plain constants so older tooling and
    // hand-written decode logic can share it.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_serial_resp_if.sv
// -----------------------------------------------------------------------------
// alu_serial_resp_if
// Request/response bus of the bit-serial ALU.
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_sel         operands and opcode
//   out_valid/out_ready        response handshake
//   out_result, out_co, out_ovf result, carry out, signed overflow
// master: the requester/consumer side; slave: the ALU.
// -----------------------------------------------------------------------------
interface alu_serial_resp_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_co;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_result, out_co, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_result, out_co, out_ovf
    );
endinterface

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
// Combinational one-bit ALU stage.
//   a, b   operand bits
//   cin    carry into this bit (ADD/SUB only)
//   sel    opcode
//   r      result bit
//   cout   carry out of this bit (0 for AND/XOR)
// SUB is A + ~B + 1: B is inverted here, the +1 arrives as the initial carry.
// -----------------------------------------------------------------------------
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_e  sel,
    output logic r,
    output logic cout
);

    logic bx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        bx   = b ^ (sel == OP_SUB);
        case (sel)
            OP_ADD, OP_SUB: begin
                r    = a ^ bx ^ cin;
                cout = (a & bx) | (a & cin) | (bx & cin);
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_resp.sv
// -----------------------------------------------------------------------------
// alu_serial_resp
// Bit-serial ALU with valid/ready request and response handshakes.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_serial_resp_if slave port (request, response, result flags)
// One request is captured in IDLE, WIDTH cycles compute one bit each (LSB
// first) in EXEC, and the result is held in DONE until out_ready.
// -----------------------------------------------------------------------------
module alu_serial_resp
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_resp_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              sel_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sr;
    logic             co_q;
    logic             ovf_q;

    logic             slice_r;
    logic             slice_co;
    logic             is_arith;

    alu_bit_slice u_slice (
        .a    (a_q[cnt]),
        .b    (b_q[cnt]),
        .cin  (carry),
        .sel  (sel_q),
        .r    (slice_r),
        .cout (slice_co)
    );

    assign is_arith = (sel_q == OP_ADD) || (sel_q == OP_SUB);

    // NOTE: reset is sampled only on the clock edge, so it sits inside the
    // clocked block and the sensitivity list holds clk alone.
    // NOTE: state registers use non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= OP_ADD;
            cnt   <= '0;
            carry <= 1'b0;
            sr    <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        sel_q <= op_e'(bus.in_sel);
                        cnt   <= '0;
                        // The +1 of A + ~B + 1 enters as the initial carry.
                        carry <= (op_e'(bus.in_sel) == OP_SUB);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // New bit enters at the MSB; after WIDTH shifts bit 0
                    // has reached the LSB and the word is aligned.
                    sr    <= {slice_r, sr[WIDTH-1:1]};
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Overflow: carry into the MSB differs from carry out.
                        co_q  <= is_arith & slice_co;
                        ovf_q <= is_arith & (carry ^ slice_co);
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Leaving DONE never accepts in the same edge: IDLE is
                    // only reached after this edge.
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.out_valid  = (state == ST_DONE);
    assign bus.out_result = sr;
    assign bus.out_co     = co_q;
    assign bus.out_ovf    = ovf_q;

endmodule

// File: doc/alu_serial_resp.md
ALU_SERIAL_RESP -- requirements
Module: alu_serial_resp

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (two's complement).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  request carries a valid operation.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_a  input  WIDTH  signed operand A.
REQ-007 in_b  input  WIDTH  signed operand B.
REQ-008 in_sel  input  2  opcode: 0 ADD, 1 SUB (A-B), 2 AND, 3 XOR.
REQ-009 out_valid  output  1  result registers hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_result  output  WIDTH  signed result, modulo 2^WIDTH.
REQ-012 out_co  output  1  carry out of MSB (ADD/SUB); 0 for AND/XOR.
REQ-013 out_ovf  output  1  signed overflow (ADD/SUB); 0 for AND/XOR.

Function
REQ-014 FSM states IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Handshake: request accepted on a rising edge with in_valid=1 and in_ready=1; in_a, in_b and in_sel SHALL be captured into internal registers on that edge.
REQ-016 IDLE -> EXEC on accept; bit counter cleared to 0, carry register loaded with 0 for ADD and 1 for SUB.
REQ-017 EXEC: one result bit per cycle, LSB first; bit i computed from captured A[i], B[i] (inverted for SUB) and carry register; counter increments.
REQ-018 EXEC -> DONE on the edge that processes bit WIDTH-1; out_valid SHALL be 1 exactly WIDTH cycles after the accept edge.
REQ-019 On DONE entry: out_co = final carry; out_ovf = carry-into-MSB XOR carry-out-of-MSB; AND/XOR force both to 0.
REQ-020 SUB SHALL be implemented as A + ~B + 1; out_co=1 means no borrow.
REQ-021 DONE: out_result, out_co and out_ovf SHALL be held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
REQ-022 DONE -> IDLE on the edge with out_ready=1; out_valid deasserts on that edge; no new request is accepted on that same edge.
REQ-023 Throughput: at most one operation per WIDTH+2 cycles.
REQ-024 Input changes on in_a/in_b/in_sel after acceptance SHALL NOT affect the operation in flight.
REQ-025 in_valid while not IDLE SHALL be ignored (request stays pending on the interface).

Reset
REQ-026 rst_n=0 sampled on a rising edge SHALL force IDLE, in_ready=1, out_valid=0, out_result=0, out_co=0, out_ovf=0, counter=0, carry=0.
REQ-027 Reset asserted mid-EXEC or in DONE SHALL abort the operation with no result emitted; first accept is allowed on the first edge after rst_n returns to 1.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_XOR=3), the FSM state type and the default WIDTH.
REQ-029 One sub-module alu_bit_slice SHALL compute one result bit and carry-out from (a, b, cin, sel), combinationally.
REQ-030 Result SHALL be assembled in a shift register (MSB-in, shifting right) so out_result is fully aligned on DONE entry.

Verification
REQ-031 ADD A=0x6A B=0x26 -> out_result=0x90, co=0, ovf=1, out_valid exactly 8 cycles after accept.
REQ-032 ADD A=0x80 B=0xED -> 0x6D, co=1, ovf=1; SUB A=0x3D B=0x07 -> 0x36, co=1, ovf=0.
REQ-033 AND A=0xEB B=0xC3 -> 0xC3, co=0, ovf=0; XOR A=0x7F B=0x0F -> 0x70, co=0, ovf=0.
REQ-034 Backpressure: out_ready=0 for 20 cycles after DONE -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 Reset at EXEC bit 4 of SUB 0x3D-0xF9 -> next cycle IDLE, all outputs 0, no out_valid; following ADD 0x01+0x1B -> 0x1C.
REQ-036 Operand churn: change in_a/in_b every cycle during EXEC -> result equals that of the captured operands.
